axis_switch_arbiter: RTL and testbench
======================================

AXIS_SWITCH_ARBITER -- requirements
Module: axis_switch_arbiter

Interface
REQ-001 Parameter SHALL be NSLAVES, default 2, number of requesting slave ports (legal range 2..16).
REQ-002 Parameter SHALL be HAS_LAST, default 0: 1 releases a grant on TLAST, 0 releases it on the burst quota.
REQ-003 Parameter SHALL be MAX_BURST, default 16, beats per grant when HAS_LAST=0 (legal range 1..256).
REQ-004 Port SHALL be aclk, input, 1, the single clock; all logic on its rising edge.
REQ-005 Port SHALL be areset, input, 1, synchronous, active-high reset.
REQ-006 Port SHALL be s_valid, input, NSLAVES, per-slave TVALID (request).
REQ-007 Port SHALL be s_last, input, NSLAVES, per-slave TLAST; ignored when HAS_LAST=0.
REQ-008 Port SHALL be s_ready, output, NSLAVES, per-slave TREADY routed from m_ready.
REQ-009 Port SHALL be m_valid, output, 1, TVALID toward the shared master.
REQ-010 Port SHALL be m_ready, input, 1, TREADY from the shared master.
REQ-011 Port SHALL be sel, output, $clog2(NSLAVES), data/dest/id/last mux select for the datapath.
REQ-012 Port SHALL be grant, output, NSLAVES, one-hot registered grant; all-zero when idle.

Function
REQ-013 The FSM SHALL have two states: IDLE (no grant) and BUSY (one slave granted).
REQ-014 In IDLE with any s_valid set, the block SHALL register the round-robin winner and enter BUSY the next cycle: one cycle grant latency.
REQ-015 Round-robin search SHALL start at index (last_winner+1) mod NSLAVES and wrap; last_winner SHALL reset to NSLAVES-1, so index 0 wins first.
REQ-016 In BUSY, outputs SHALL be m_valid = s_valid[sel], s_ready[sel] = m_ready, and every other s_ready bit = 0.
REQ-017 In IDLE, m_valid and all s_ready bits SHALL be 0.
REQ-018 A beat SHALL be s_valid[sel] && m_ready in BUSY; only beats advance the burst counter or release the grant.
REQ-019 With HAS_LAST=1, a beat with s_last[sel]=1 SHALL release the grant.
REQ-020 With HAS_LAST=0, an 8-bit-safe beat counter SHALL count from 0, and the beat taking the count to MAX_BURST SHALL release the grant; the counter SHALL clear on release.
REQ-021 On release, if any slave other than the releasing one has s_valid, the winner SHALL be registered in the same cycle and BUSY kept, with no idle bubble.
REQ-022 On release, if only the releasing slave has s_valid, it SHALL be re-granted in the same cycle.
REQ-023 On release with no s_valid set, the FSM SHALL go to IDLE.
REQ-024 A granted slave dropping s_valid mid-packet SHALL NOT lose the grant; the grant waits until the release condition is met.
REQ-025 sel and grant SHALL change only on a grant-register update and SHALL be mutually consistent (grant = 1<<sel in BUSY).
REQ-026 last_winner SHALL update to the new sel on every grant.

Reset
REQ-027 While areset=1 at a clock edge, the block SHALL enter IDLE with grant=0, sel=0, counter=0, last_winner=NSLAVES-1.
REQ-028 During reset, m_valid=0 and s_ready=0; reset mid-packet SHALL drop the grant without completing the packet.

Structure
REQ-029 The shared package axis_switch_pkg SHALL hold the arb_state_t enum (IDLE, BUSY) and the index-width helper function.
REQ-030 The block SHALL use one sub-module, rr_priority_encoder: combinational, inputs request vector and start index, outputs winner index and found flag.
REQ-031 The arbiter SHALL contain no datapath storage; data muxing belongs to the instantiating switch.

Verification
REQ-032 Reset, then s_valid=4'b1111 held, HAS_LAST=0, MAX_BURST=2, m_ready=1 -> grants 0,1,2,3,0 each held for exactly 2 beats, with no idle cycle between them.
REQ-033 HAS_LAST=1, slave 2 sends 5 beats (last on beat 5) while slave 0 is valid -> grant stays 2 through beat 5, then moves to 0 the next cycle.
REQ-034 HAS_LAST=1, granted slave 1 deasserts s_valid for 3 cycles mid-packet while slave 3 is valid -> grant stays 1 and m_valid=0 during the gap.
REQ-035 m_ready=0 for 10 cycles with slave 0 granted -> counter does not advance, s_ready=0 everywhere, grant unchanged.
REQ-036 Only slave 3 valid, HAS_LAST=0, MAX_BURST=1 -> slave 3 is re-granted every beat with m_valid held at 1.
REQ-037 areset asserted mid-packet -> next cycle grant=0 and m_valid=0; after release, slave 0 wins first.

Source files
------------

// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the AXI-Stream switch arbiter.
package axis_switch_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Width of an index into n ports, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_switch_arbiter_if.sv
// Handshake and select bundle between the slave ports, the arbiter and the shared master.
interface axis_switch_arbiter_if #(
  parameter int NSLAVES = 2
) ();
  import axis_switch_pkg::*;

  logic [NSLAVES-1:0]            s_valid;
  logic [NSLAVES-1:0]            s_last;
  logic [NSLAVES-1:0]            s_ready;
  logic                          m_valid;
  logic                          m_ready;
  logic [idx_w(NSLAVES)-1:0]     sel;
  logic [NSLAVES-1:0]            grant;

  modport master (
    input  s_valid, s_last, m_ready,
    output s_ready, m_valid, sel, grant
  );

  modport slave (
    output s_valid, s_last, m_ready,
    input  s_ready, m_valid, sel, grant
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_priority_encoder
  import axis_switch_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   start,
  output logic [idx_w(N)-1:0]   winner,
  output logic                  found
);

  localparam int IW = idx_w(N);
  localparam logic [IW:0] N_EXT = (IW+1)'(N);

  // Scan candidates in rotated order; the first hit wins.
  always_comb begin
    logic [IW:0]   sum_v;
    logic [IW-1:0] idx_v;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum_v = {1'b0, start} + (IW+1)'(i);
      if (sum_v >= N_EXT) begin
        sum_v = sum_v - N_EXT;
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[IW-1:0];
      if (!found && req[idx_v]) begin
        found  = 1'b1;
        winner = idx_v;
      end else begin
        found  = found;
      end
    end
  end

endmodule

// File: rtl/axis_switch_arbiter.sv
// Round-robin grant arbiter for an N:1 AXI-Stream switch; releases on TLAST or a beat quota.
module axis_switch_arbiter
  import axis_switch_pkg::*;
#(
  parameter int NSLAVES   = 2,
  parameter int HAS_LAST  = 0,
  parameter int MAX_BURST = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_switch_arbiter_if.master bus
);

  localparam int                IW         = idx_w(NSLAVES);
  localparam logic [7:0]        QUOTA_LAST = 8'(MAX_BURST - 1);
  localparam logic [NSLAVES-1:0] ONE_HOT0  = NSLAVES'(1);
  localparam logic [IW-1:0]     LAST_IDX   = IW'(NSLAVES - 1);

  arb_state_t          state_r, state_s;
  logic [IW-1:0]       sel_r, sel_s;
  logic [IW-1:0]       last_winner_r, last_winner_s;
  logic [NSLAVES-1:0]  grant_r, grant_s;
  logic [7:0]          cnt_r, cnt_s;
  logic [IW-1:0]       start_s, winner_s;
  logic                found_s, beat_s, release_s;

  // Search begins just after the previous winner so every requester gets a turn.
  always_comb begin
    if (last_winner_r == LAST_IDX) begin
      start_s = '0;
    end else begin
      start_s = last_winner_r + IW'(1);
    end
  end

  rr_priority_encoder #(.N(NSLAVES)) u_rr (
    .req    (bus.s_valid),
    .start  (start_s),
    .winner (winner_s),
    .found  (found_s)
  );

  // Beat and grant-release qualification for the granted slave.
  always_comb begin
    beat_s = (state_r == BUSY) && bus.s_valid[sel_r] && bus.m_ready;
    if (HAS_LAST != 0) begin
      release_s = beat_s && bus.s_last[sel_r];
    end else begin
      release_s = beat_s && (cnt_r == QUOTA_LAST);
    end
  end

  // State and grant registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r       <= IDLE;
      sel_r         <= '0;
      grant_r       <= '0;
      cnt_r         <= 8'd0;
      last_winner_r <= LAST_IDX;
    end else begin
      state_r       <= state_s;
      sel_r         <= sel_s;
      grant_r       <= grant_s;
      cnt_r         <= cnt_s;
      last_winner_r <= last_winner_s;
    end
  end

  // Next-state logic; a release re-arbitrates in the same cycle to avoid a bubble.
  always_comb begin
    state_s       = state_r;
    sel_s         = sel_r;
    grant_s       = grant_r;
    cnt_s         = cnt_r;
    last_winner_s = last_winner_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s       = BUSY;
          sel_s         = winner_s;
          grant_s       = ONE_HOT0 << winner_s;
          last_winner_s = winner_s;
          cnt_s         = 8'd0;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (release_s) begin
          cnt_s = 8'd0;
          if (found_s) begin
            state_s       = BUSY;
            sel_s         = winner_s;
            grant_s       = ONE_HOT0 << winner_s;
            last_winner_s = winner_s;
          end else begin
            state_s = IDLE;
            grant_s = '0;
          end
        end else if (beat_s) begin
          cnt_s = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Handshake routing: only the granted slave sees the master's ready.
  always_comb begin
    bus.m_valid = 1'b0;
    bus.s_ready = '0;
    if ((state_r == BUSY) && !areset) begin
      bus.m_valid        = bus.s_valid[sel_r];
      bus.s_ready[sel_r] = bus.m_ready;
    end else begin
      bus.m_valid = 1'b0;
    end
  end

  assign bus.sel   = sel_r;
  assign bus.grant = grant_r;

endmodule

// File: tb/tb_axis_switch_arbiter.sv
// Directed table-driven bench for axis_switch_arbiter across quota and TLAST configurations.
module tb_axis_switch_arbiter;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 aclk = ~aclk;

  axis_switch_arbiter_if #(.NSLAVES(4)) if_q2 ();
  axis_switch_arbiter_if #(.NSLAVES(4)) if_last ();
  axis_switch_arbiter_if #(.NSLAVES(4)) if_q1 ();

  axis_switch_arbiter #(.NSLAVES(4), .HAS_LAST(0), .MAX_BURST(2)) u_q2 (
    .aclk(aclk), .areset(areset), .bus(if_q2));
  axis_switch_arbiter #(.NSLAVES(4), .HAS_LAST(1), .MAX_BURST(16)) u_last (
    .aclk(aclk), .areset(areset), .bus(if_last));
  axis_switch_arbiter #(.NSLAVES(4), .HAS_LAST(0), .MAX_BURST(1)) u_q1 (
    .aclk(aclk), .areset(areset), .bus(if_q1));

  typedef struct {
    logic [3:0] s_valid;
    logic [3:0] s_last;
    logic       m_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       m_valid;
    logic [3:0] s_ready;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    if_q2.s_valid = 4'b0000;   if_q2.s_last = 4'b0000;   if_q2.m_ready = 1'b0;
    if_last.s_valid = 4'b0000; if_last.s_last = 4'b0000; if_last.m_ready = 1'b0;
    if_q1.s_valid = 4'b0000;   if_q1.s_last = 4'b0000;   if_q1.m_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [3:0] g,
                              input logic [1:0] s, input logic mv, input logic [3:0] sr);
    vec_t t;
    t.s_valid = v; t.s_last = 4'b0000; t.m_ready = r;
    t.grant = g; t.sel = s; t.m_valid = mv; t.s_ready = sr;
    return t;
  endfunction

  initial begin
    // Quota=2 rotation over four requesters, then a 10-cycle master stall.
    tbl[0]  = mk(4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000);
    tbl[1]  = mk(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001);
    tbl[2]  = mk(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001);
    tbl[3]  = mk(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010);
    tbl[4]  = mk(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010);
    tbl[5]  = mk(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100);
    tbl[6]  = mk(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100);
    tbl[7]  = mk(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000);
    tbl[8]  = mk(4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000);
    tbl[9]  = mk(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001);
    for (int i = 10; i < 20; i++) begin
      tbl[i] = mk(4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0000);
    end
    tbl[20] = mk(4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001);
    tbl[21] = mk(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010);

    // Reset state, with requests present to show outputs stay quiet.
    clear_inputs();
    if_q2.s_valid = 4'b1111;
    if_q2.m_ready = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_grant", {28'd0, if_q2.grant}, 32'd0);
    chk("rst_sel", {30'd0, if_q2.sel}, 32'd0);
    chk("rst_m_valid", {31'd0, if_q2.m_valid}, 32'd0);
    chk("rst_s_ready", {28'd0, if_q2.s_ready}, 32'd0);
    chk("rst_grant_last", {28'd0, if_last.grant}, 32'd0);
    chk("rst_grant_q1", {28'd0, if_q1.grant}, 32'd0);
    areset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      if_q2.s_valid = tbl[i].s_valid;
      if_q2.s_last  = tbl[i].s_last;
      if_q2.m_ready = tbl[i].m_ready;
      #1;
      chk($sformatf("tbl%0d_grant", i), {28'd0, if_q2.grant}, {28'd0, tbl[i].grant});
      chk($sformatf("tbl%0d_sel", i), {30'd0, if_q2.sel}, {30'd0, tbl[i].sel});
      chk($sformatf("tbl%0d_m_valid", i), {31'd0, if_q2.m_valid}, {31'd0, tbl[i].m_valid});
      chk($sformatf("tbl%0d_s_ready", i), {28'd0, if_q2.s_ready}, {28'd0, tbl[i].s_ready});
      @(posedge aclk);
      #1;
    end

    // TLAST: slave 2 sends 5 beats while slave 0 waits.
    do_reset();
    if_last.m_ready = 1'b1;
    if_last.s_valid = 4'b0100;
    #1;
    chk("last5_idle", {28'd0, if_last.grant}, 32'd0);
    @(posedge aclk); #1;
    if_last.s_valid = 4'b0101;
    for (int b = 1; b <= 5; b++) begin
      if_last.s_last = (b == 5) ? 4'b0100 : 4'b0000;
      #1;
      chk($sformatf("last5_b%0d_grant", b), {28'd0, if_last.grant}, 32'h4);
      chk($sformatf("last5_b%0d_m_valid", b), {31'd0, if_last.m_valid}, 32'd1);
      @(posedge aclk); #1;
    end
    if_last.s_last = 4'b0000;
    #1;
    chk("last5_next_grant", {28'd0, if_last.grant}, 32'h1);
    chk("last5_next_sel", {30'd0, if_last.sel}, 32'd0);

    // TLAST: granted slave 1 pauses for 3 cycles while slave 3 waits.
    do_reset();
    if_last.m_ready = 1'b1;
    if_last.s_valid = 4'b0010;
    @(posedge aclk); #1;
    if_last.s_valid = 4'b1010;
    #1;
    chk("gap_start_grant", {28'd0, if_last.grant}, 32'h2);
    @(posedge aclk); #1;
    if_last.s_valid = 4'b1000;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk($sformatf("gap%0d_grant", g), {28'd0, if_last.grant}, 32'h2);
      chk($sformatf("gap%0d_m_valid", g), {31'd0, if_last.m_valid}, 32'd0);
      chk($sformatf("gap%0d_s_ready", g), {28'd0, if_last.s_ready}, 32'h2);
      @(posedge aclk); #1;
    end
    if_last.s_valid = 4'b1010;
    if_last.s_last  = 4'b0010;
    #1;
    chk("gap_end_m_valid", {31'd0, if_last.m_valid}, 32'd1);
    @(posedge aclk); #1;
    if_last.s_last = 4'b0000;
    #1;
    chk("gap_next_grant", {28'd0, if_last.grant}, 32'h8);
    chk("gap_next_sel", {30'd0, if_last.sel}, 32'd3);

    // Reset mid-packet on slave 3, then slave 0 wins first.
    if_last.s_valid = 4'b1001;
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("midrst_grant", {28'd0, if_last.grant}, 32'd0);
    chk("midrst_m_valid", {31'd0, if_last.m_valid}, 32'd0);
    chk("midrst_s_ready", {28'd0, if_last.s_ready}, 32'd0);
    areset = 1'b0;
    #1;
    chk("postrst_idle", {28'd0, if_last.grant}, 32'd0);
    @(posedge aclk); #1;
    chk("postrst_grant", {28'd0, if_last.grant}, 32'h1);
    chk("postrst_sel", {30'd0, if_last.sel}, 32'd0);

    // Quota=1 with a lone requester: re-granted every beat, no bubble.
    do_reset();
    if_q1.m_ready = 1'b1;
    if_q1.s_valid = 4'b1000;
    #1;
    chk("q1_idle_m_valid", {31'd0, if_q1.m_valid}, 32'd0);
    @(posedge aclk); #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("q1_%0d_grant", k), {28'd0, if_q1.grant}, 32'h8);
      chk($sformatf("q1_%0d_sel", k), {30'd0, if_q1.sel}, 32'd3);
      chk($sformatf("q1_%0d_m_valid", k), {31'd0, if_q1.m_valid}, 32'd1);
      chk($sformatf("q1_%0d_s_ready", k), {28'd0, if_q1.s_ready}, 32'h8);
      @(posedge aclk); #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
